rtt_stamper: RTL and testbench
==============================

// Module: rtt_stamper
// PURPOSE
//  Pass-through pipeline stage directly downstream of the probe generator in the rtt_probe
//  user datapath. Identifies probe frames by EtherType and overwrites one body word with a
//  free-running 64-bit cycle timestamp at the moment that word leaves the block.
//  All other traffic passes unmodified. Exposes a probe count and the last stamp as status.
// PARAMETERS
//  DATA_WIDTH       64       datapath width; must equal 64 (timestamp width)
//  CTRL_WIDTH       8        DATA_WIDTH/8
//  PROBE_ETYPE      16'h0801 EtherType marking a probe frame
//  STAMP_WORD       2        index of the stamped data word (0 = DA word); legal range 2..255
// PORTS
//  clk          in   1    core clock
//  reset        in   1    asynchronous, active-low reset (asserted when 0)
//  in_data      in   64   upstream word
//  in_ctrl      in   8    upstream ctrl; !=0 marks module header or EOP word
//  in_wr        in   1    upstream write strobe
//  in_rdy       out  1    space available; = !fifo_nearly_full
//  out_data     out  64   downstream word (stamped when selected)
//  out_ctrl     out  8    downstream ctrl, always = FIFO head ctrl
//  out_wr       out  1    downstream write strobe
//  out_rdy      in   1    downstream can accept a word
//  stamp_en     in   1    enables stamping; sampled per packet
//  probe_cnt    out  32   count of probe frames forwarded (wraps at 2^32)
//  last_stamp   out  64   timestamp written into the most recent probe
// BEHAVIOUR
//  - Reset: state=MOD_HDRS, word_idx=0, ts=0, probe_cnt=0, last_stamp=0, FIFO empty,
//    out_wr=0, in_rdy=1 after reset release. Reset mid-packet discards FIFO contents.
//  - Input buffered in a 4-deep fallthrough FIFO. out_wr = !empty && out_rdy; pop on out_wr.
//    Zero added latency: head word visible on out_data combinationally. No bubbles inserted.
//  - ts: 64-bit counter, +1 every clk, wraps modulo 2^64; never stalls.
//  - FSM on popped words only:
//     MOD_HDRS: ctrl!=0 -> stay; ctrl==0 -> PKT_DATA, word_idx<=1, en_lat<=stamp_en, is_probe<=0.
//     PKT_DATA: ctrl==0 -> word_idx++ (saturate at 255); ctrl!=0 (EOP) -> MOD_HDRS.
//  - Probe detect: popped word with word_idx==1 and data[31:16]==PROBE_ETYPE sets is_probe.
//  - Stamp: popped word with ctrl==0, word_idx==STAMP_WORD, is_probe, en_lat -> out_data=ts
//    (value of ts in the pop cycle); last_stamp<=ts same edge; probe_cnt++ same edge.
//  - Frame ending (EOP) before STAMP_WORD: no stamp, no count, no status update.
//  - EOP word itself is never stamped even if its index matches.
//  - out_rdy low: head held, no pop, FSM/word_idx/is_probe frozen; ts keeps counting, so
//    stamp reflects actual departure cycle.
//  - stamp_en toggling mid-packet has no effect until next packet start.
//  - Simultaneous pop and push on full FIFO: legal; in_rdy derives from nearly_full only.
// STRUCTURE
//  - Shared package/defines: PROBE_ETYPE default, STATE encodings (MOD_HDRS=1, PKT_DATA=2,
//    one-hot), IO_QUEUE_STAGE_NUM already global.
//  - One sub-module: fallthrough_small_fifo (WIDTH=72, MAX_DEPTH_BITS=2), its reset driven
//    by !reset; all other flops in this block async-cleared on reset==0.
//  - Stamp mux, detect compare and counters stay in this module (~200 lines).
// TESTING
//  1 Probe frame (hdr, DA/SA, SA+0801, 5 body, EOP), stamp_en=1, out_rdy=1 -> word 2 data ==
//    ts at its out_wr cycle; probe_cnt 0->1; last_stamp equals that word; others bit-exact.
//  2 Same frame with EtherType 0x0800 -> output bit-identical to input, probe_cnt stays 0.
//  3 Probe frame, out_rdy held low 10 cycles before word 2 -> stamp = departure ts (pre-stall
//    value +10 or more), no word lost or duplicated, order preserved.
//  4 stamp_en 1->0 after first data word of probe -> that frame stamped; next probe untouched,
//    probe_cnt increments only once.
//  5 Short probe (DA, SA+0801, EOP) -> unmodified, probe_cnt unchanged; following probe stamped.
//  6 Assert reset=0 mid-frame with FIFO full -> out_wr=0, in_rdy=1, counters 0; next clean
//    frame forwarded and stamped correctly, ts restarts from 0.

Source files
------------

// File: rtl/rtt_stamper_pkg.sv
`default_nettype none
// ============================================================================
// Package : rtt_stamper_pkg
// Shared constants, state encoding and helpers for the probe stamper.
// Rev     : 1.0
// ============================================================================
package rtt_stamper_pkg;

  localparam logic [15:0] c_probe_etype = 16'h0801;
  localparam int          c_ts_width    = 64;

  typedef enum logic [1:0] {
    MOD_HDRS = 2'b01,
    PKT_DATA = 2'b10
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtt_stamper_fifo.sv
`default_nettype none
// ============================================================================
// Module : fallthrough_small_fifo
// Small first-word-fallthrough FIFO; head word is always visible on dout.
// Rev    : 1.0
// ============================================================================
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2,
  parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int                    c_depth = 2**MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] c_full_cnt = (MAX_DEPTH_BITS+1)'(c_depth);
  localparam logic [MAX_DEPTH_BITS:0] c_nf_cnt   = (MAX_DEPTH_BITS+1)'(NEARLY_FULL);

  logic [WIDTH-1:0]          r_mem [c_depth];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_count;
  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;

  assign empty       = (r_count == '0);
  assign w_full      = (r_count == c_full_cnt);
  assign nearly_full = (r_count >= c_nf_cnt);
  assign dout        = r_mem[r_rd_ptr];
  assign w_pop       = rd_en && !empty;
  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_push      = wr_en && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rtt_stamper.sv
`default_nettype none
// ============================================================================
// Module : rtt_stamper
// Pass-through stage that overwrites one body word of probe frames with the departure cycle count.
// Rev    : 1.0
// ============================================================================
module rtt_stamper
  import rtt_stamper_pkg::*;
#(
  parameter int          DATA_WIDTH  = 64,
  parameter int          CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter logic [15:0] PROBE_ETYPE = c_probe_etype,
  parameter int          STAMP_WORD  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  stamp_en,
  output logic [31:0]           probe_cnt,
  output logic [63:0]           last_stamp
);

  localparam int         c_fifo_width = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [7:0] c_stamp_idx  = 8'(STAMP_WORD);

  logic [c_fifo_width-1:0] w_head;
  logic [DATA_WIDTH-1:0]   w_head_data;
  logic [CTRL_WIDTH-1:0]   w_head_ctrl;
  logic                    w_head_is_data;
  logic                    w_empty;
  logic                    w_nearly_full;
  logic                    w_fifo_rst;
  logic                    w_pop;
  logic                    w_detect;
  logic                    w_stamp;

  state_t                  r_state;
  logic [7:0]              r_word_idx;
  logic                    r_is_probe;
  logic                    r_en_lat;
  logic [c_ts_width-1:0]   r_ts;
  logic [31:0]             r_probe_cnt;
  logic [c_ts_width-1:0]   r_last_stamp;

  assign w_fifo_rst = !reset;

  fallthrough_small_fifo #(
    .WIDTH          (c_fifo_width),
    .MAX_DEPTH_BITS (2)
  ) u_fifo (
    .clk         (clk),
    .rst         (w_fifo_rst),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (w_pop),
    .dout        (w_head),
    .nearly_full (w_nearly_full),
    .empty       (w_empty)
  );

  assign w_head_data    = w_head[DATA_WIDTH-1:0];
  assign w_head_ctrl    = w_head[c_fifo_width-1:DATA_WIDTH];
  assign w_head_is_data = (w_head_ctrl == '0);
  assign w_pop          = !w_empty && out_rdy;

  assign w_detect = (r_state == PKT_DATA) && (r_word_idx == 8'd1) &&
                    (w_head_data[31:16] == PROBE_ETYPE);
  // Stamp uses ts of the pop cycle itself, so stalls are reflected in the value.
  assign w_stamp  = w_pop && (r_state == PKT_DATA) && w_head_is_data &&
                    (r_word_idx == c_stamp_idx) && r_is_probe && r_en_lat;

  assign in_rdy     = !w_nearly_full;
  assign out_wr     = w_pop;
  assign out_ctrl   = w_head_ctrl;
  assign out_data   = w_stamp ? r_ts : w_head_data;
  assign probe_cnt  = r_probe_cnt;
  assign last_stamp = r_last_stamp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= MOD_HDRS;
      r_word_idx   <= '0;
      r_is_probe   <= 1'b0;
      r_en_lat     <= 1'b0;
      r_ts         <= '0;
      r_probe_cnt  <= '0;
      r_last_stamp <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_stamp) begin
        r_last_stamp <= r_ts;
        r_probe_cnt  <= r_probe_cnt + 32'd1;
      end
      if (w_pop) begin
        case (r_state)
          MOD_HDRS: begin
            if (w_head_is_data) begin
              r_state    <= PKT_DATA;
              r_word_idx <= 8'd1;
              r_en_lat   <= stamp_en;
              r_is_probe <= 1'b0;
            end
          end
          PKT_DATA: begin
            if (w_head_is_data) begin
              r_word_idx <= sat_inc8(r_word_idx);
            end else begin
              r_state    <= MOD_HDRS;
              r_word_idx <= '0;
            end
            if (w_detect) begin
              r_is_probe <= 1'b1;
            end
          end
          default: r_state <= MOD_HDRS;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtt_stamper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_rtt_stamper
// Directed and randomized frames against a frame-level reference model of rtt_stamper.
// Rev    : 1.0
// ============================================================================
module tb_rtt_stamper;

  localparam logic [15:0] c_etype      = 16'h0801;
  localparam int          c_stamp_word = 2;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [63:0] in_data  = '0;
  logic [7:0]  in_ctrl  = '0;
  logic        in_wr    = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy  = 1'b1;
  logic        stamp_en = 1'b1;
  logic [31:0] probe_cnt;
  logic [63:0] last_stamp;

  rtt_stamper dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_wr      (in_wr),
    .in_rdy     (in_rdy),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_wr     (out_wr),
    .out_rdy    (out_rdy),
    .stamp_en   (stamp_en),
    .probe_cnt  (probe_cnt),
    .last_stamp (last_stamp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    bit          is_da;
    bit          stamp;
  } exp_t;

  exp_t        exp_q[$];
  logic [71:0] frame_q[$];
  exp_t        me;
  logic [71:0] want;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pops     = 0;
  logic [63:0] cyc;
  logic [31:0] m_cnt    = '0;
  logic [63:0] m_last   = '0;
  bit          m_en     = 1'b0;
  bit          rdy_rand = 1'b0, rdy_force = 1'b1;
  bit          en_rand  = 1'b0, en_force  = 1'b1;
  bit          gaps     = 1'b0;
  logic [63:0] t0;
  logic [31:0] cnt_before;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cycles elapsed since reset release: the value the timestamp must carry.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= '0;
    else        cyc <= cyc + 64'd1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_rdy  = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
      stamp_en = en_rand ? 1'($urandom_range(0, 1)) : en_force;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset && out_wr) begin
        pops++;
        check("pop_expected", 72'(exp_q.size() != 0), 72'd1);
        if (exp_q.size() != 0) begin
          me   = exp_q.pop_front();
          if (me.is_da) m_en = stamp_en;
          want = me.w;
          if (me.stamp && m_en) begin
            want[63:0] = cyc;
            m_cnt      = m_cnt + 32'd1;
            m_last     = cyc;
          end
          check("out_word", {out_ctrl, out_data}, want);
        end
      end
    end
  end

  task automatic build(input int nh, input int nd, input logic [15:0] et);
    logic [63:0] d;
    frame_q.delete();
    for (int k = 0; k < nh; k++) frame_q.push_back({8'($urandom_range(1, 255)), $urandom, $urandom});
    for (int k = 0; k < nd; k++) begin
      d = {$urandom, $urandom};
      if (k == 1) d[31:16] = et;
      frame_q.push_back({8'h00, d});
    end
    d = {$urandom, $urandom};
    frame_q.push_back({8'(1 << $urandom_range(0, 7)), d});
  endtask

  task automatic send_frame();
    int nh = 0;
    int nd;
    int stamp_k = -1;
    int waited;
    while (nh < frame_q.size() && frame_q[nh][71:64] != 8'h00) nh++;
    nd = frame_q.size() - nh - 1;
    if (nd > c_stamp_word && frame_q[nh+1][31:16] == c_etype) stamp_k = nh + c_stamp_word;
    for (int k = 0; k < frame_q.size(); k++) begin
      waited = 0;
      while (1) begin
        @(posedge clk);
        #1;
        if (in_rdy && (!gaps || $urandom_range(0, 3) != 0)) break;
        in_wr = 1'b0;
        waited++;
        if (waited > 500) begin
          check("in_rdy_wait", 72'(in_rdy), 72'd1);
          return;
        end
      end
      in_wr   = 1'b1;
      in_ctrl = frame_q[k][71:64];
      in_data = frame_q[k][63:0];
      exp_q.push_back('{w: frame_q[k], is_da: (k == nh), stamp: (k == stamp_k)});
    end
    @(posedge clk);
    #1;
    in_wr = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("drain", 72'(exp_q.size()), 72'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_pops(input int target);
    int t = 0;
    while (pops < target && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (pops < target) check("pop_wait", 72'(pops), 72'(target));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_probe_cnt"}, 72'(probe_cnt), 72'(m_cnt));
    check({tag, "_last_stamp"}, 72'(last_stamp), 72'(m_last));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #3;
    check("rst_out_wr", 72'(out_wr), 72'd0);
    check("rst_in_rdy", 72'(in_rdy), 72'd1);
    check("rst_probe_cnt", 72'(probe_cnt), 72'd0);
    check("rst_last_stamp", 72'(last_stamp), 72'd0);
    reset = 1'b1;

    // Basic probe frame: hdr, DA, SA+etype, 5 body, EOP.
    build(1, 7, c_etype);
    send_frame();
    wait_drain();
    check_status("t1");

    // Non-probe EtherType passes bit-exact.
    build(1, 7, 16'h0800);
    send_frame();
    wait_drain();
    check_status("t2");

    // Hold the stamp word at the head for ten cycles.
    build(1, 7, c_etype);
    fork
      send_frame();
      begin : stall_ctl
        wait_pops(pops + 3);
        t0        = cyc;
        rdy_force = 1'b0;
        repeat (10) @(posedge clk);
        rdy_force = 1'b1;
      end
    join
    wait_drain();
    check_status("t3");
    check("t3_stall_stamp", 72'(last_stamp >= t0 + 64'd10), 72'd1);

    // stamp_en dropped after the DA word left: this frame stamped, next one not.
    cnt_before = probe_cnt;
    build(1, 7, c_etype);
    fork
      send_frame();
      begin : en_ctl
        wait_pops(pops + 2);
        en_force = 1'b0;
      end
    join
    wait_drain();
    build(1, 7, c_etype);
    send_frame();
    wait_drain();
    check_status("t4");
    check("t4_cnt_delta", 72'(probe_cnt - cnt_before), 72'd1);
    en_force = 1'b1;

    // Short probe ends before the stamp word, then a normal probe.
    build(0, 2, c_etype);
    send_frame();
    wait_drain();
    check_status("t5a");
    build(0, 5, c_etype);
    send_frame();
    wait_drain();
    check_status("t5b");

    // Reset with a full FIFO.
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      in_wr   = 1'b1;
      in_ctrl = (k == 0) ? 8'hff : 8'h00;
      in_data = {$urandom, $urandom};
      @(posedge clk);
    end
    #1;
    in_wr = 1'b0;
    check("t6_full_in_rdy", 72'(in_rdy), 72'd0);
    @(posedge clk);
    rdy_force = 1'b1;
    #3;
    check("t6_out_wr_before", 72'(out_wr), 72'd1);
    reset = 1'b0;
    #1;
    check("t6_out_wr", 72'(out_wr), 72'd0);
    check("t6_in_rdy", 72'(in_rdy), 72'd1);
    check("t6_probe_cnt", 72'(probe_cnt), 72'd0);
    check("t6_last_stamp", 72'(last_stamp), 72'd0);
    exp_q.delete();
    m_cnt  = '0;
    m_last = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    build(1, 6, c_etype);
    send_frame();
    wait_drain();
    check_status("t6");
    check("t6_ts_restart", 72'(last_stamp < 64'd40), 72'd1);

    // Randomized traffic, back-pressure, gaps and stamp_en toggling.
    rdy_rand = 1'b1;
    en_rand  = 1'b1;
    gaps     = 1'b1;
    for (int f = 0; f < 40; f++) begin
      build($urandom_range(0, 2), $urandom_range(1, 10),
            ($urandom_range(0, 2) != 0) ? c_etype : 16'($urandom));
      send_frame();
    end
    wait_drain();
    check_status("rand");
    rdy_rand = 1'b0;
    en_rand  = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
